// File: rtl/keycode_pkg.sv
// keycode_pkg: shared types for the keycode event sequencer.
//   evt_kind_t - event type carried with each queued keycode
//   state_t    - press/repeat sequencer states
//   key_evt_t  - one FIFO entry {kind, code}, 10 bits
package keycode_pkg;

    localparam logic [7:0] KEY_NONE = 8'h00;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_REPEAT  = 2'd1,
        EVT_RELEASE = 2'd2
    } evt_kind_t;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT,
        SWITCH
    } state_t;

    typedef struct packed {
        evt_kind_t  kind;
        logic [7:0] code;
    } key_evt_t;

endpackage

// File: rtl/keycode_event_ctrl_if.sv
// keycode_event_ctrl_if: valid/ready event channel to the game logic.
//   evt_valid - head event present (producer)
//   evt_code  - keycode of head event (producer)
//   evt_kind  - 0 PRESS, 1 REPEAT, 2 RELEASE (producer)
//   evt_ready - consumer takes the head event
interface keycode_event_ctrl_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic [1:0] evt_kind;

    modport master (output evt_valid, output evt_code, output evt_kind, input evt_ready);
    modport slave  (input evt_valid, input evt_code, input evt_kind, output evt_ready);
endinterface

// File: rtl/keycode_evt_fifo.sv
// keycode_evt_fifo: synchronous FIFO of key_evt_t entries.
//   push/push_evt - write request; accepted when not full, or full with a pop
//   pop           - read request; ignored when empty
//   head          - oldest entry, read straight from the storage registers
//   count         - occupancy; full/empty flags
module keycode_evt_fifo
    import keycode_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  key_evt_t      push_evt,
    input  logic          pop,
    output key_evt_t      head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    key_evt_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CW-1:0]   r_count;
    logic            w_pop_ok;
    logic            w_push_ok;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_pop_ok  = pop & ~empty;
    // When full, the slot being freed by the pop is the one written.
    assign w_push_ok = push & (~full | w_pop_ok);
    assign head      = r_mem[r_rd];
    assign count     = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem   <= '{default: '0};
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr] <= push_evt;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop_ok)
                r_rd <= r_rd + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/keycode_event_ctrl.sv
// keycode_event_ctrl: debounces the raw keycode level and turns it into
// PRESS / REPEAT / RELEASE events with typematic repeat, queued in a FIFO.
//   clk, reset_n  - clock, async active-low reset
//   keycode_in    - raw keycode level, 8'h00 = no key
//   enable        - event generation enable
//   clr_overflow  - clears the sticky overflow flag
//   evt           - event channel (valid/ready, code, kind)
//   fifo_count    - FIFO occupancy
//   overflow      - sticky: an event was dropped on a full FIFO
//   held_code     - currently accepted (filtered) keycode
module keycode_event_ctrl
    import keycode_pkg::*;
#(
    parameter int STABLE_CYCLES = 50000,
    parameter int DELAY_CYCLES  = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [7:0]                  keycode_in,
    input  logic                        enable,
    input  logic                        clr_overflow,
    keycode_event_ctrl_if.master        evt,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic [7:0]                  held_code
);

    localparam int MAXC = (DELAY_CYCLES > REPEAT_CYCLES) ? DELAY_CYCLES : REPEAT_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int SCW  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    // filter
    logic [7:0]     r_kc_q;
    logic [7:0]     r_cand;
    logic [SCW-1:0] r_cnt;
    logic [7:0]     r_filt;
    logic [7:0]     w_cand_nxt;
    logic [SCW-1:0] w_cnt_nxt;

    // sequencer
    state_t         r_state, w_state_nxt;
    logic [TW-1:0]  r_timer, w_timer_nxt;
    logic [7:0]     r_code, w_code_nxt;
    logic           r_ovf;
    logic           w_push;
    key_evt_t       w_push_evt;

    // fifo
    key_evt_t       w_head;
    logic           w_full;
    logic           w_empty;
    logic           w_pop;

    always_comb begin
        w_cand_nxt = r_cand;
        w_cnt_nxt  = r_cnt;
        if (r_kc_q != r_cand) begin
            w_cand_nxt = r_kc_q;
            w_cnt_nxt  = '0;
        end else if (r_cnt != SCW'(STABLE_CYCLES - 1)) begin
            w_cnt_nxt = r_cnt + SCW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_kc_q <= KEY_NONE;
            r_cand <= KEY_NONE;
            r_cnt  <= '0;
            r_filt <= KEY_NONE;
        end else begin
            r_kc_q <= keycode_in;
            r_cand <= w_cand_nxt;
            r_cnt  <= w_cnt_nxt;
            // Accept on the same edge the counter reaches its terminal value,
            // which also covers STABLE_CYCLES=1 (terminal on candidate load).
            if (w_cnt_nxt == SCW'(STABLE_CYCLES - 1))
                r_filt <= w_cand_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_code_nxt  = r_code;
        w_push      = 1'b0;
        w_push_evt  = '{kind: EVT_PRESS, code: r_filt};
        if (!enable) begin
            w_state_nxt = IDLE;
            w_timer_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_filt != KEY_NONE) begin
                        w_push      = 1'b1;
                        w_code_nxt  = r_filt;
                        w_timer_nxt = TW'(DELAY_CYCLES - 1);
                        w_state_nxt = DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    // A key change wins over a due repeat so the release is never lost.
                    if (r_filt != r_code) begin
                        w_push      = 1'b1;
                        w_push_evt  = '{kind: EVT_RELEASE, code: r_code};
                        w_code_nxt  = r_filt;
                        w_timer_nxt = '0;
                        w_state_nxt = (r_filt == KEY_NONE) ? IDLE : SWITCH;
                    end else if (r_timer == '0) begin
                        w_push      = 1'b1;
                        w_push_evt  = '{kind: EVT_REPEAT, code: r_code};
                        w_timer_nxt = TW'(REPEAT_CYCLES - 1);
                        w_state_nxt = REPEAT;
                    end else begin
                        w_timer_nxt = r_timer - TW'(1);
                    end
                end
                SWITCH: begin
                    w_push      = 1'b1;
                    w_push_evt  = '{kind: EVT_PRESS, code: r_code};
                    w_timer_nxt = TW'(DELAY_CYCLES - 1);
                    w_state_nxt = DELAY;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_pop = ~w_empty & evt.evt_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_code  <= KEY_NONE;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_code  <= w_code_nxt;
            if (w_push & w_full & ~w_pop)
                r_ovf <= 1'b1;
            else if (clr_overflow)
                r_ovf <= 1'b0;
        end
    end

    keycode_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (w_push),
        .push_evt (w_push_evt),
        .pop      (w_pop),
        .head     (w_head),
        .count    (fifo_count),
        .full     (w_full),
        .empty    (w_empty)
    );

    assign evt.evt_valid = ~w_empty;
    assign evt.evt_code  = w_head.code;
    assign evt.evt_kind  = w_head.kind;
    assign overflow      = r_ovf;
    assign held_code     = r_filt;

endmodule

// File: tb/tb_keycode_event_ctrl.sv
// tb_keycode_event_ctrl: directed checks of filtering, press/repeat/release
// timing, key switching, FIFO overflow, async reset and enable gating.
// Inputs change 1 time unit after a rising edge; "cycle t" is the interval
// after rising edge t, counted from the cycle the key is first applied.
module tb_keycode_event_ctrl;

    localparam int K_PRESS = 0, K_REPEAT = 1, K_RELEASE = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] keycode_in;
    logic       enable;
    logic       clr_overflow;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [7:0] held_code;

    int checks = 0;
    int errors = 0;

    keycode_event_ctrl_if evt_if ();

    keycode_event_ctrl #(
        .STABLE_CYCLES (2),
        .DELAY_CYCLES  (8),
        .REPEAT_CYCLES (4),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .keycode_in   (keycode_in),
        .enable       (enable),
        .clr_overflow (clr_overflow),
        .evt          (evt_if.master),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .held_code    (held_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n          = 1'b0;
        keycode_in       = 8'h00;
        enable           = 1'b1;
        clr_overflow     = 1'b0;
        evt_if.evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic chk_evt(input string tag, input int kind, input int code);
        chk({tag, "_valid"}, int'(evt_if.evt_valid), 1);
        chk({tag, "_kind"}, int'(evt_if.evt_kind), kind);
        chk({tag, "_code"}, int'(evt_if.evt_code), code);
    endtask

    initial begin
        int exp_v;

        // 1: press, auto-repeat, release
        do_reset();
        chk("rst_valid", int'(evt_if.evt_valid), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_held", int'(held_code), 0);
        chk("rst_code", int'(evt_if.evt_code), 0);
        keycode_in = 8'h1A;
        tick(3);
        chk("t1_held", int'(held_code), 'h1A);
        chk("t1_early", int'(evt_if.evt_valid), 0);
        tick(1);
        chk_evt("t1_press", K_PRESS, 'h1A);
        for (int t = 5; t <= 32; t++) begin
            tick(1);
            if (t == 26) keycode_in = 8'h00;
            exp_v = (t == 12 || t == 16 || t == 20 || t == 24 || t == 28 || t == 30) ? 1 : 0;
            chk($sformatf("t1_valid_c%0d", t), int'(evt_if.evt_valid), exp_v);
            if (exp_v == 1) begin
                chk($sformatf("t1_kind_c%0d", t), int'(evt_if.evt_kind), (t == 30) ? K_RELEASE : K_REPEAT);
                chk($sformatf("t1_code_c%0d", t), int'(evt_if.evt_code), 'h1A);
            end
            if (t == 29) chk("t1_held_rel", int'(held_code), 0);
        end

        // 2: one-cycle glitch is filtered out
        do_reset();
        keycode_in = 8'h04;
        tick(1);
        keycode_in = 8'h00;
        for (int t = 1; t <= 8; t++) begin
            tick(1);
            chk($sformatf("t2_held_c%0d", t), int'(held_code), 0);
            chk($sformatf("t2_count_c%0d", t), int'(fifo_count), 0);
        end

        // 3: direct switch 1A -> 16
        do_reset();
        keycode_in = 8'h1A;
        tick(4);
        chk_evt("t3_press", K_PRESS, 'h1A);
        tick(2);
        keycode_in = 8'h16;
        for (int t = 7; t <= 19; t++) begin
            tick(1);
            exp_v = (t == 10 || t == 11 || t == 19) ? 1 : 0;
            chk($sformatf("t3_valid_c%0d", t), int'(evt_if.evt_valid), exp_v);
            if (t == 9)  chk("t3_held", int'(held_code), 'h16);
            if (t == 10) chk_evt("t3_rel", K_RELEASE, 'h1A);
            if (t == 11) chk_evt("t3_press2", K_PRESS, 'h16);
            if (t == 19) chk_evt("t3_rep", K_REPEAT, 'h16);
        end

        // 4: stalled consumer, overflow, clear, drain order
        do_reset();
        evt_if.evt_ready = 1'b0;
        keycode_in = 8'h07;
        for (int t = 1; t <= 44; t++) begin
            tick(1);
            if (t == 40) keycode_in = 8'h00;
            if (t == 4)  chk("t4_cnt4", int'(fifo_count), 1);
            if (t == 12) chk("t4_cnt12", int'(fifo_count), 2);
            if (t == 20) chk("t4_cnt20", int'(fifo_count), 4);
            if (t == 23) chk("t4_ovf23", int'(overflow), 0);
            if (t == 24) begin
                chk("t4_ovf24", int'(overflow), 1);
                chk("t4_cnt24", int'(fifo_count), 4);
            end
        end
        tick(2);
        chk("t4_ovf_hold", int'(overflow), 1);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        chk("t4_ovf_clr", int'(overflow), 0);
        evt_if.evt_ready = 1'b1;
        chk_evt("t4_d0", K_PRESS, 'h07);
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            chk_evt($sformatf("t4_d%0d", i), K_REPEAT, 'h07);
        end
        tick(1);
        chk("t4_empty", int'(evt_if.evt_valid), 0);

        // 5: async reset mid-repeat with queued events
        do_reset();
        evt_if.evt_ready = 1'b0;
        keycode_in = 8'h1A;
        tick(13);
        chk("t5_cnt", int'(fifo_count), 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_valid", int'(evt_if.evt_valid), 0);
        chk("t5_rst_count", int'(fifo_count), 0);
        chk("t5_rst_code", int'(evt_if.evt_code), 0);
        chk("t5_rst_held", int'(held_code), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(3);
        chk("t5_early", int'(evt_if.evt_valid), 0);
        tick(1);
        chk_evt("t5_press", K_PRESS, 'h1A);

        // 6: enable gating, drain while disabled, re-enable with key held
        do_reset();
        evt_if.evt_ready = 1'b0;
        keycode_in = 8'h1A;
        tick(13);
        chk("t6_cnt", int'(fifo_count), 2);
        enable = 1'b0;
        for (int t = 14; t <= 25; t++) begin
            tick(1);
            chk($sformatf("t6_cnt_c%0d", t), int'(fifo_count), 2);
        end
        chk("t6_held", int'(held_code), 'h1A);
        evt_if.evt_ready = 1'b1;
        chk_evt("t6_d0", K_PRESS, 'h1A);
        tick(1);
        chk_evt("t6_d1", K_REPEAT, 'h1A);
        tick(1);
        chk("t6_empty", int'(evt_if.evt_valid), 0);
        tick(2);
        chk("t6_no_rel", int'(evt_if.evt_valid), 0);
        enable = 1'b1;
        tick(1);
        chk_evt("t6_press", K_PRESS, 'h1A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
